// File: rtl/ac97_slotbuf_pkg.sv
// Shared constants, FSM encoding and the sample-to-slot justify helper for the
// AC'97 downstream slot buffer.
package ac97_pkg;

  localparam int AC97_SLOT_W     = 20;
  localparam int AC97_MAX_PCM_CH = 10;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } slotbuf_state_e;

  // Sample arrives zero-extended in the LSBs; move it to the slot MSBs.
  function automatic logic [AC97_SLOT_W-1:0] justify(input logic [AC97_SLOT_W-1:0] sample,
                                                     input int sw);
    return sample << (AC97_SLOT_W - sw);
  endfunction

endpackage

// File: rtl/ac97_slotbuf_if.sv
// DMA-to-slot-buffer sample write port (strobe/ack handshake).
interface ac97_slotbuf_if #(
  parameter int SW = 16
) ();

  logic          in_stb;
  logic          in_ack;
  logic [SW-1:0] in_data;

  modport master (output in_stb, output in_data, input in_ack);
  modport slave  (input in_stb, input in_data, output in_ack);

endinterface

// File: rtl/ac97_slotbuf_fifo.sv
// Whole-frame synchronous FIFO; read data is registered on pop and can be
// zeroed by clr so the consumer sees a clean idle payload.
module ac97_slotbuf_fifo
  import ac97_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     clr,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  rd_data_q, rd_data_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      rd_data_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end else if (clr) begin
        rd_data_d = '0;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;

endmodule

// File: rtl/ac97_slotbuf.sv
// Multi-channel downstream PCM slot buffer with prime/underrun control.
// Define AC97_SLOTBUF_UFCNT_EN to add the saturating underrun counter port ufcnt.
module ac97_slotbuf
  import ac97_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int SW    = 16,
  parameter int DEPTH = 16,
  parameter int PRIME = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       en,
  input  logic [NCH-1:0]             chan_mask,
  ac97_slotbuf_if.slave              wr,
  input  logic                       next_frame,
  output logic [NCH-1:0]             slot_valid,
  output logic [AC97_SLOT_W*NCH-1:0] slot_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underrun,
  output logic                       lowwater
`ifdef AC97_SLOTBUF_UFCNT_EN
  ,
  output logic [15:0]                ufcnt
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int FW    = NCH * SW;
  localparam int WCH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WCH_W-1:0] WCH_LAST = WCH_W'(NCH - 1);

  logic [LW-1:0]    fifo_level;
  logic [FW-1:0]    fifo_rd_data;
  logic [FW-1:0]    frame_data;
  logic             in_ack;
  logic             accept;
  logic             push;
  logic             pop;
  logic             clr;

  logic [SW-1:0]    asm_q [NCH];
  logic [SW-1:0]    asm_d [NCH];
  logic [WCH_W-1:0] wch_q, wch_d;
  slotbuf_state_e   state_q, state_d;
  logic [NCH-1:0]   slot_valid_q, slot_valid_d;
  logic             underrun_q, underrun_d;
  logic             lowwater_q, lowwater_d;

  assign in_ack    = sys_rst_n & en & (fifo_level < LW'(DEPTH));
  assign wr.in_ack = in_ack;
  assign accept    = wr.in_stb & in_ack;

  // The last channel's sample bypasses its lane so the frame commits the same cycle.
  always_comb begin
    asm_d = asm_q;
    wch_d = wch_q;
    push  = 1'b0;
    if (!en) begin
      wch_d = '0;
      for (int i = 0; i < NCH; i++) asm_d[i] = '0;
    end else if (accept) begin
      asm_d[wch_q] = wr.in_data;
      if (wch_q == WCH_LAST) begin
        push  = 1'b1;
        wch_d = '0;
      end else begin
        wch_d = wch_q + WCH_W'(1);
      end
    end
    frame_data = '0;
    for (int i = 0; i < NCH; i++) frame_data[i*SW +: SW] = asm_d[i];
  end

  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    underrun_d   = 1'b0;
    pop          = 1'b0;
    clr          = 1'b0;
    if (!en) begin
      state_d      = FILL;
      slot_valid_d = '0;
    end else if (next_frame) begin
      case (state_q)
        FILL: begin
          if (fifo_level >= LW'(PRIME)) begin
            state_d = RUN;
            pop     = 1'b1;
          end
        end
        RUN: begin
          if (fifo_level != '0) begin
            pop = 1'b1;
          end else begin
            state_d    = FILL;
            underrun_d = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
      if (pop) begin
        slot_valid_d = chan_mask;
      end else begin
        slot_valid_d = '0;
        clr          = 1'b1;
      end
    end
    lowwater_d = en & pop & ~push & (fifo_level == LW'(DEPTH / 2));
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= FILL;
      slot_valid_q <= '0;
      underrun_q   <= 1'b0;
      lowwater_q   <= 1'b0;
      wch_q        <= '0;
      for (int i = 0; i < NCH; i++) asm_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      underrun_q   <= underrun_d;
      lowwater_q   <= lowwater_d;
      wch_q        <= wch_d;
      asm_q        <= asm_d;
    end
  end

  ac97_slotbuf_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .flush     (~en),
    .push      (push),
    .push_data (frame_data),
    .pop       (pop),
    .clr       (clr),
    .rd_data   (fifo_rd_data),
    .level     (fifo_level)
  );

  always_comb begin
    slot_data = '0;
    for (int i = 0; i < NCH; i++)
      slot_data[i*AC97_SLOT_W +: AC97_SLOT_W] = justify(AC97_SLOT_W'(fifo_rd_data[i*SW +: SW]), SW);
  end

  assign slot_valid = slot_valid_q;
  assign level      = fifo_level;
  assign underrun   = underrun_q;
  assign lowwater   = lowwater_q;

`ifdef AC97_SLOTBUF_UFCNT_EN
  logic [15:0] ufcnt_q, ufcnt_d;

  always_comb begin
    ufcnt_d = ufcnt_q;
    if (!en) ufcnt_d = '0;
    else if (underrun_d && (ufcnt_q != 16'hFFFF)) ufcnt_d = ufcnt_q + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) ufcnt_q <= '0;
    else            ufcnt_q <= ufcnt_d;
  end

  assign ufcnt = ufcnt_q;
`endif

endmodule
